// File: rtl/data_memory_arbiter_if.sv
// Bundle of core-side request/response signals and the single data memory port
// seen by data_memory_arbiter.
interface data_memory_arbiter_if #(
    parameter int cores      = 4,
    parameter int addr_width = 32,
    parameter int data_width = 32
);
    logic [cores-1:0]            req;
    logic [cores-1:0]            we;
    logic [cores*addr_width-1:0] addr;
    logic [cores*data_width-1:0] wdata;
    logic [cores-1:0]            ack;
    logic [data_width-1:0]       rdata;
    logic [addr_width-1:0]       mem_addr;
    logic                        mem_we;
    logic [data_width-1:0]       mem_wdata;
    logic [data_width-1:0]       mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output ack, rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  ack, rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter serialising core loads/stores onto one single-port data
// memory; each transaction is granted, accessed for one cycle, then acknowledged.
module data_memory_arbiter #(
    parameter int cores      = 4,
    parameter int addr_width = 32,
    parameter int data_width = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_arbiter_if.slave bus
);
    localparam int idx_width = (cores > 1) ? $clog2(cores) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [idx_width-1:0]   ptr_r;
    logic [idx_width-1:0]   sel_r;
    logic [idx_width-1:0]   win_idx_s;
    logic                   win_valid_s;
    logic [cores-1:0]       cand_s;
    logic [cores-1:0]       ack_r;
    logic [cores-1:0]       ack_next_s;
    logic [data_width-1:0]  rdata_r;
    logic [data_width-1:0]  rdata_next_s;
    logic [addr_width-1:0]  mem_addr_r;
    logic [addr_width-1:0]  mem_addr_next_s;
    logic                   mem_we_r;
    logic                   mem_we_next_s;
    logic [data_width-1:0]  mem_wdata_r;
    logic [data_width-1:0]  mem_wdata_next_s;

    function automatic logic [cores-1:0] onehot(input logic [idx_width-1:0] idx);
        logic [cores-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [idx_width-1:0] wrap_inc(input logic [idx_width-1:0] idx);
        int k;
        k = int'(idx) + 1;
        if (k >= cores) begin
            return '0;
        end else begin
            return idx_width'(k);
        end
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Round-robin scan from ptr; the just-acknowledged core is masked in DONE.
    always_comb begin
        int j;
        cand_s      = '0;
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        j           = 0;
        case (state_r)
            IDLE:    cand_s = bus.req;
            DONE:    cand_s = bus.req & ~onehot(sel_r);
            default: cand_s = '0;
        endcase
        for (int i = 0; i < cores; i++) begin
            j = int'(ptr_r) + i;
            j = (j >= cores) ? (j - cores) : j;
            if (cand_s[j] && !win_valid_s) begin
                win_valid_s = 1'b1;
                win_idx_s   = idx_width'(j);
            end else begin
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE:    state_next_s = win_valid_s ? ACCESS : IDLE;
            ACCESS:  state_next_s = DONE;
            DONE:    state_next_s = win_valid_s ? ACCESS : IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; the memory port registers double
    // as the latched request fields, so they are nonzero only during ACCESS.
    always_comb begin
        ack_next_s       = '0;
        rdata_next_s     = rdata_r;
        mem_addr_next_s  = '0;
        mem_we_next_s    = 1'b0;
        mem_wdata_next_s = '0;
        if (state_r == ACCESS) begin
            ack_next_s   = onehot(sel_r);
            rdata_next_s = bus.mem_rdata;
        end else begin
            ack_next_s   = '0;
        end
        if (win_valid_s) begin
            mem_addr_next_s  = addr_width'(bus.addr >> (int'(win_idx_s) * addr_width));
            mem_wdata_next_s = data_width'(bus.wdata >> (int'(win_idx_s) * data_width));
            mem_we_next_s    = bus.we[win_idx_s];
        end else begin
            mem_addr_next_s  = '0;
            mem_wdata_next_s = '0;
            mem_we_next_s    = 1'b0;
        end
    end

    // Output, selection and pointer registers; sel/ptr move only on a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_r       <= '0;
            rdata_r     <= '0;
            mem_addr_r  <= '0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= '0;
            sel_r       <= '0;
            ptr_r       <= '0;
        end else begin
            ack_r       <= ack_next_s;
            rdata_r     <= rdata_next_s;
            mem_addr_r  <= mem_addr_next_s;
            mem_we_r    <= mem_we_next_s;
            mem_wdata_r <= mem_wdata_next_s;
            if (win_valid_s) begin
                sel_r <= win_idx_s;
                ptr_r <= wrap_inc(win_idx_s);
            end else begin
                sel_r <= sel_r;
                ptr_r <= ptr_r;
            end
        end
    end

    assign bus.ack       = ack_r;
    assign bus.rdata     = rdata_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_wdata = mem_wdata_r;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural single-port memory;
// inputs change and outputs are sampled on the falling clock edge.
module tb_data_memory_arbiter;
    localparam int cores = 4;
    localparam int aw    = 32;
    localparam int dw    = 32;

    logic clk = 1'b0;
    logic reset;
    logic [dw-1:0] mem [0:63];
    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] e;
    int k0;
    int k3;
    logic [31:0] exp_rd [0:3];

    data_memory_arbiter_if #(.cores(cores), .addr_width(aw), .data_width(dw)) bus_if ();

    data_memory_arbiter #(.cores(cores), .addr_width(aw), .data_width(dw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    assign bus_if.mem_rdata = mem[bus_if.mem_addr[5:0]];

    always @(posedge clk) begin
        if (bus_if.mem_we) mem[bus_if.mem_addr[5:0]] <= bus_if.mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        bus_if.req[i]            = r;
        bus_if.we[i]             = w;
        bus_if.addr[i*aw +: aw]  = a;
        bus_if.wdata[i*dw +: dw] = d;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        bus_if.req   = '0;
        bus_if.we    = '0;
        bus_if.addr  = '0;
        bus_if.wdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;

        // Reset state
        do_reset();
        check("rst_ack", bus_if.ack, 4'b0000);
        check("rst_rdata", bus_if.rdata, 32'd0);
        check("rst_maddr", bus_if.mem_addr, 32'd0);
        check("rst_mwe", bus_if.mem_we, 1'b0);
        check("rst_mwdata", bus_if.mem_wdata, 32'd0);

        // Single read: core 2 loads mem[3]=5
        mem[3] = 32'd5;
        drive(2, 1'b1, 1'b0, 32'd3, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            check("t1_ack", bus_if.ack, (c == 2) ? 4'b0100 : 4'b0000);
            if (c == 1) check("t1_maddr", bus_if.mem_addr, 32'd3);
            if (c == 2) begin
                check("t1_rdata", bus_if.rdata, 32'd5);
                drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end

        // Simultaneous reads from all cores after reset
        do_reset();
        mem[0] = 32'd14; mem[1] = 32'd12; mem[2] = 32'd13; mem[3] = 32'd5;
        exp_rd[0] = 32'd14; exp_rd[1] = 32'd12; exp_rd[2] = 32'd13; exp_rd[3] = 32'd5;
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b0, i, 32'd0);
        for (int c = 1; c <= 9; c++) begin
            cyc();
            e = (((c % 2) == 0) && (c <= 8)) ? (4'b0001 << (c / 2 - 1)) : 4'b0000;
            check("t2_ack", bus_if.ack, e);
            if (e != 4'b0000) begin
                check("t2_rdata", bus_if.rdata, exp_rd[c / 2 - 1]);
                drive(c / 2 - 1, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end

        // Write-before-read with ptr=1 (set up by one core-0 transaction)
        do_reset();
        drive(0, 1'b1, 1'b0, 32'd0, 32'd0);
        cyc();
        cyc();
        check("t3_pre_ack", bus_if.ack, 4'b0001);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        mem[9] = 32'd0;
        drive(1, 1'b1, 1'b1, 32'd9, 32'd14);
        drive(2, 1'b1, 1'b0, 32'd9, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            check("t3_ack", bus_if.ack, (c == 2) ? 4'b0010 : ((c == 4) ? 4'b0100 : 4'b0000));
            if (c == 1) begin
                check("t3_mwe1", bus_if.mem_we, 1'b1);
                check("t3_mwdata", bus_if.mem_wdata, 32'd14);
            end
            if (c == 2) drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
            if (c == 3) begin
                check("t3_mwe3", bus_if.mem_we, 1'b0);
                check("t3_maddr", bus_if.mem_addr, 32'd9);
            end
            if (c == 4) begin
                check("t3_rdata", bus_if.rdata, 32'd14);
                drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        check("t3_mem9", mem[9], 32'd14);

        // Fairness: core 0 stores, core 3 loads the same addresses
        do_reset();
        for (int i = 20; i < 24; i++) mem[i] = 32'd0;
        k0 = 0;
        k3 = 0;
        drive(0, 1'b1, 1'b1, 32'd20, 32'd100);
        drive(3, 1'b1, 1'b0, 32'd20, 32'd0);
        for (int c = 1; c <= 16; c++) begin
            cyc();
            e = 4'b0000;
            if ((c % 2) == 0) e = (((c / 2) % 2) == 1) ? 4'b0001 : 4'b1000;
            check("t4_ack", bus_if.ack, e);
            check("t4_mwe", bus_if.mem_we, ((c % 4) == 1) ? 1'b1 : 1'b0);
            if (e[0]) begin
                k0++;
                drive(0, k0 < 4, 1'b1, 20 + k0, 100 + k0);
            end
            if (e[3]) begin
                check("t4_rdata", bus_if.rdata, 100 + k3);
                k3++;
                drive(3, k3 < 4, 1'b0, 20 + k3, 32'd0);
            end
        end
        cyc();

        // Stale-request masking: core 1 holds req through its DONE cycle
        drive(1, 1'b1, 1'b0, 32'd3, 32'd0);
        for (int c = 1; c <= 7; c++) begin
            cyc();
            check("t5_ack", bus_if.ack, ((c == 2) || (c == 7)) ? 4'b0010 : 4'b0000);
            if (c == 3) begin
                check("t5_idle_maddr", bus_if.mem_addr, 32'd0);
                check("t5_idle_mwe", bus_if.mem_we, 1'b0);
                drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
            end
            if (c == 5) drive(1, 1'b1, 1'b0, 32'd0, 32'd0);
            if (c == 7) begin
                check("t5_rdata", bus_if.rdata, 32'd14);
                drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        cyc();

        // Reset during the ACCESS cycle of a core-0 store
        mem[4] = 32'd0;
        drive(0, 1'b1, 1'b1, 32'd4, 32'd7);
        cyc();
        check("t6_mwe", bus_if.mem_we, 1'b1);
        check("t6_maddr", bus_if.mem_addr, 32'd4);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        reset = 1'b0;
        check("t6_ack", bus_if.ack, 4'b0000);
        check("t6_maddr0", bus_if.mem_addr, 32'd0);
        check("t6_mwe0", bus_if.mem_we, 1'b0);
        check("t6_mwdata0", bus_if.mem_wdata, 32'd0);
        check("t6_rdata0", bus_if.rdata, 32'd0);
        check("t6_mem4", mem[4], 32'd7);
        for (int c = 3; c <= 4; c++) begin
            cyc();
            check("t6_noack", bus_if.ack, 4'b0000);
        end
        // ptr back at 0: core 1 beats core 3
        drive(1, 1'b1, 1'b0, 32'd0, 32'd0);
        drive(3, 1'b1, 1'b0, 32'd1, 32'd0);
        cyc();
        cyc();
        check("t6_ptr_ack", bus_if.ack, 4'b0010);
        check("t6_ptr_rdata", bus_if.rdata, 32'd14);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(3, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
